chess_board_writer: RTL and testbench

- Producer of the packed 64-square board bus that the VGA renderer reads each pixel.
- Holds chess position, cursor and selection state as registers.
- Updates state from single-cycle button pulses.
- Piece moves are committed only on a frame-start strobe, so a frame never shows a half-applied move.

---
 rtl/chess_board_writer.sv | 202 ++++++++++++++++++++
 tb/tb_chess_board_writer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chess_board_writer.sv
// -----------------------------------------------------------------------------
// chess_board_writer
//
// Purpose:
//   Owns the chess position, cursor and selection state and presents them as a
//   packed 64-square board bus for the VGA renderer. Cursor moves and
//   selections react to single-cycle button pulses. A chosen move is held
//   until the next frame-start strobe, so a displayed frame never shows a
//   half-applied move.
//
// Square s = row*8 + col (row 0 top, col 0 left), field F(s) = board_data[s*12 +: 12]:
//   +2 selected-source marker, +3 cursor, +7 occupied, +8 camp (1 = black),
//   +9..+11 piece code MSB..LSB (001 K, 010 Q, 011 B, 100 N, 101 R, 110 P).
//
// Ports:
//   pclk        in   pixel/system clock, rising edge
//   rst         in   synchronous active-high reset
//   btn_up      in   pulse, cursor row-1
//   btn_down    in   pulse, cursor row+1
//   btn_left    in   pulse, cursor col-1
//   btn_right   in   pulse, cursor col+1
//   btn_center  in   pulse, select / drop / deselect
//   frame_start in   pulse at start of vertical blanking
//   board_data  out  packed board, 768 bits, registered
//   turn        out  camp to move
//   state       out  00 BROWSE, 01 HOLD, 10 COMMIT_WAIT
//   move_done   out  one-cycle pulse when a move is committed
// -----------------------------------------------------------------------------
module chess_board_writer #(
  parameter logic [5:0] INIT_CURSOR = 6'd60,
  parameter logic       FIRST_CAMP  = 1'b0
) (
  input  logic         pclk,
  input  logic         rst,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_left,
  input  logic         btn_right,
  input  logic         btn_center,
  input  logic         frame_start,
  output logic [767:0] board_data,
  output logic         turn,
  output logic [1:0]   state,
  output logic         move_done
);

  typedef enum logic [1:0] {
    BROWSE      = 2'b00,
    HOLD        = 2'b01,
    COMMIT_WAIT = 2'b10
  } state_t;

  // Bit offset of the 12-bit field belonging to a square.
  function automatic logic [9:0] fieldBase(input logic [5:0] sq);
    return 10'(sq) * 10'd12;
  endfunction

  // Occupied field carrying a piece of the given camp and code.
  function automatic logic [11:0] pieceField(input logic camp, input logic [2:0] code);
    logic [11:0] f;
    f     = '0;
    f[7]  = 1'b1;
    f[8]  = camp;
    f[9]  = code[2];
    f[10] = code[1];
    f[11] = code[0];
    return f;
  endfunction

  // Back-rank order R N B Q K B N R.
  function automatic logic [2:0] backCode(input logic [2:0] col);
    case (col)
      3'd0, 3'd7: return 3'b101;
      3'd1, 3'd6: return 3'b100;
      3'd2, 3'd5: return 3'b011;
      3'd3:       return 3'b010;
      default:    return 3'b001;
    endcase
  endfunction

  // Standard starting position with the cursor bit placed on the given square.
  function automatic logic [767:0] initialBoard(input logic [5:0] cur);
    logic [767:0] b;
    b = '0;
    for (int c = 0; c < 8; c++) begin
      b[fieldBase(6'(c))      +: 12] = pieceField(1'b1, backCode(3'(c)));
      b[fieldBase(6'(8 + c))  +: 12] = pieceField(1'b1, 3'b110);
      b[fieldBase(6'(48 + c)) +: 12] = pieceField(1'b0, 3'b110);
      b[fieldBase(6'(56 + c)) +: 12] = pieceField(1'b0, backCode(3'(c)));
    end
    b[fieldBase(cur) + 10'd3] = 1'b1;
    return b;
  endfunction

  logic [767:0] board_q, board_d;
  logic [5:0]   cursor_q, cursor_d;
  logic [5:0]   src_q, src_d;
  logic [5:0]   dst_q, dst_d;
  state_t       state_q, state_d;
  logic         turn_q, turn_d;
  logic         move_done_q, move_done_d;

  logic [9:0]   curBase, srcBase, dstBase;
  logic         curOwn;
  logic [5:0]   newCursor;

  assign curBase = fieldBase(cursor_q);
  assign srcBase = fieldBase(src_q);
  assign dstBase = fieldBase(dst_q);

  // A square "belongs" to the player to move when it is occupied by that camp.
  assign curOwn = board_q[curBase + 10'd7] && (board_q[curBase + 10'd8] == turn_q);

  // Next-state logic. Only one button action is taken per cycle: center wins,
  // then up, down, left, right. In COMMIT_WAIT buttons are ignored and only
  // frame_start can complete the pending move.
  always_comb begin
    board_d     = board_q;
    cursor_d    = cursor_q;
    src_d       = src_q;
    dst_d       = dst_q;
    state_d     = state_q;
    turn_d      = turn_q;
    move_done_d = 1'b0;
    newCursor   = cursor_q;

    if (state_q == COMMIT_WAIT) begin
      if (frame_start) begin
        // Piece bits only: the cursor bit of either square is left alone, and
        // a capture simply overwrites whatever sat on the destination.
        board_d[dstBase + 10'd7 +: 5] = board_q[srcBase + 10'd7 +: 5];
        board_d[srcBase + 10'd7 +: 5] = 5'd0;
        board_d[srcBase + 10'd2]      = 1'b0;
        turn_d      = ~turn_q;
        move_done_d = 1'b1;
        state_d     = BROWSE;
      end
    end else if (state_q == BROWSE || state_q == HOLD) begin
      if (btn_center) begin
        if (state_q == BROWSE) begin
          if (curOwn) begin
            src_d                    = cursor_q;
            board_d[curBase + 10'd2] = 1'b1;
            state_d                  = HOLD;
          end
        end else if (cursor_q == src_q) begin
          board_d[srcBase + 10'd2] = 1'b0;
          state_d                  = BROWSE;
        end else if (!curOwn) begin
          // Own-camp destinations are rejected; anything else is accepted.
          dst_d   = cursor_q;
          state_d = COMMIT_WAIT;
        end
      end else begin
        if (btn_up) begin
          if (cursor_q[5:3] != 3'd0) newCursor = cursor_q - 6'd8;
        end else if (btn_down) begin
          if (cursor_q[5:3] != 3'd7) newCursor = cursor_q + 6'd8;
        end else if (btn_left) begin
          if (cursor_q[2:0] != 3'd0) newCursor = cursor_q - 6'd1;
        end else if (btn_right) begin
          if (cursor_q[2:0] != 3'd7) newCursor = cursor_q + 6'd1;
        end
        // Clamped moves leave newCursor unchanged, so the board is untouched.
        if (newCursor != cursor_q) begin
          board_d[curBase + 10'd3]              = 1'b0;
          board_d[fieldBase(newCursor) + 10'd3] = 1'b1;
          cursor_d                              = newCursor;
        end
      end
    end else begin
      state_d = BROWSE;
    end
  end

  // State registers; reset wins over everything, including a pending commit.
  always_ff @(posedge pclk) begin
    if (rst) begin
      board_q     <= initialBoard(INIT_CURSOR);
      cursor_q    <= INIT_CURSOR;
      src_q       <= INIT_CURSOR;
      dst_q       <= INIT_CURSOR;
      state_q     <= BROWSE;
      turn_q      <= FIRST_CAMP;
      move_done_q <= 1'b0;
    end else begin
      board_q     <= board_d;
      cursor_q    <= cursor_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      state_q     <= state_d;
      turn_q      <= turn_d;
      move_done_q <= move_done_d;
    end
  end

  assign board_data = board_q;
  assign turn       = turn_q;
  assign state      = state_q;
  assign move_done  = move_done_q;

endmodule

// File: tb/tb_chess_board_writer.sv
// -----------------------------------------------------------------------------
// tb_chess_board_writer
//
// Purpose:
//   Drives chess_board_writer with a directed game fragment followed by random
//   button / frame_start / reset traffic, and compares every output on every
//   cycle against a square-array model of the chess position. A few
//   hand-computed field values pin the model to the documented bit layout.
// -----------------------------------------------------------------------------
module tb_chess_board_writer;

  logic         pclk = 1'b0;
  logic         rst = 1'b0;
  logic         btn_up = 1'b0;
  logic         btn_down = 1'b0;
  logic         btn_left = 1'b0;
  logic         btn_right = 1'b0;
  logic         btn_center = 1'b0;
  logic         frame_start = 1'b0;
  logic [767:0] board_data;
  logic         turn;
  logic [1:0]   state;
  logic         move_done;

  localparam logic [4:0] BC = 5'b10000;
  localparam logic [4:0] BU = 5'b01000;
  localparam logic [4:0] BD = 5'b00100;
  localparam logic [4:0] BL = 5'b00010;
  localparam logic [4:0] BR = 5'b00001;
  localparam logic [4:0] BN = 5'b00000;

  chess_board_writer #(
    .INIT_CURSOR(6'd60),
    .FIRST_CAMP (1'b0)
  ) dut (
    .pclk       (pclk),
    .rst        (rst),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_center (btn_center),
    .frame_start(frame_start),
    .board_data (board_data),
    .turn       (turn),
    .state      (state),
    .move_done  (move_done)
  );

  always #5 pclk = ~pclk;

  int tests = 0;
  int fails = 0;

  // Model: one entry per square, plus cursor/selection/turn bookkeeping.
  bit       mOcc  [64];
  bit       mCamp [64];
  bit [2:0] mCode [64];
  int       mCursor, mSrc, mDst, mState;
  bit       mSelected, mTurn, mMoveDone;
  bit       modelValid = 1'b0;
  int       backCodes [8] = '{5, 4, 3, 2, 1, 3, 4, 5};
  logic [767:0] expBoard;

  function automatic void modelReset();
    for (int s = 0; s < 64; s++) begin
      mOcc[s] = 0; mCamp[s] = 0; mCode[s] = 3'd0;
    end
    for (int c = 0; c < 8; c++) begin
      mOcc[c] = 1;      mCamp[c] = 1;      mCode[c] = 3'(backCodes[c]);
      mOcc[8 + c] = 1;  mCamp[8 + c] = 1;  mCode[8 + c] = 3'd6;
      mOcc[48 + c] = 1; mCamp[48 + c] = 0; mCode[48 + c] = 3'd6;
      mOcc[56 + c] = 1; mCamp[56 + c] = 0; mCode[56 + c] = 3'(backCodes[c]);
    end
    mCursor = 60; mSrc = 0; mDst = 0; mState = 0;
    mSelected = 0; mTurn = 0; mMoveDone = 0;
  endfunction

  function automatic void modelStep();
    bit own;
    int row, col;
    if (rst) begin
      modelReset();
      return;
    end
    mMoveDone = 0;
    own = mOcc[mCursor] && (mCamp[mCursor] == mTurn);
    row = mCursor / 8;
    col = mCursor % 8;
    if (mState == 2) begin
      if (frame_start) begin
        mOcc[mDst] = 1; mCamp[mDst] = mCamp[mSrc]; mCode[mDst] = mCode[mSrc];
        mOcc[mSrc] = 0; mCamp[mSrc] = 0; mCode[mSrc] = 3'd0;
        mSelected = 0; mTurn = !mTurn; mMoveDone = 1; mState = 0;
      end
    end else if (btn_center) begin
      if (mState == 0) begin
        if (own) begin mSrc = mCursor; mSelected = 1; mState = 1; end
      end else if (mCursor == mSrc) begin
        mSelected = 0; mState = 0;
      end else if (!own) begin
        mDst = mCursor; mState = 2;
      end
    end else begin
      if (btn_up) begin
        if (row > 0) row--;
      end else if (btn_down) begin
        if (row < 7) row++;
      end else if (btn_left) begin
        if (col > 0) col--;
      end else if (btn_right) begin
        if (col < 7) col++;
      end
      mCursor = row * 8 + col;
    end
  endfunction

  function automatic logic [767:0] modelBoard();
    logic [767:0] b;
    logic [11:0]  f;
    b = '0;
    for (int s = 0; s < 64; s++) begin
      f = 12'd0;
      if (mOcc[s]) begin
        f[7] = 1'b1; f[8] = mCamp[s];
        f[9] = mCode[s][2]; f[10] = mCode[s][1]; f[11] = mCode[s][0];
      end
      f[3] = (s == mCursor);
      f[2] = mSelected && (s == mSrc);
      b[s*12 +: 12] = f;
    end
    return b;
  endfunction

  // Advance the model on each active edge using the inputs it sampled.
  always @(posedge pclk) begin
    modelStep();
    if (rst) modelValid = 1'b1;
  end

  // Compare every output shortly after each active edge.
  always @(posedge pclk) begin
    #2;
    if (modelValid) begin
      expBoard = modelBoard();
      tests++;
      if (board_data !== expBoard) begin
        fails++;
        $display("[TB] FAIL board_data t=%0t: got %h expected %h", $time, board_data, expBoard);
      end
      tests++;
      if (turn !== mTurn) begin
        fails++;
        $display("[TB] FAIL turn t=%0t: got %b expected %b", $time, turn, mTurn);
      end
      tests++;
      if (state !== 2'(mState)) begin
        fails++;
        $display("[TB] FAIL state t=%0t: got %b expected %b", $time, state, 2'(mState));
      end
      tests++;
      if (move_done !== mMoveDone) begin
        fails++;
        $display("[TB] FAIL move_done t=%0t: got %b expected %b", $time, move_done, mMoveDone);
      end
    end
  end

  function automatic logic [11:0] getField(input int s);
    return board_data[s*12 +: 12];
  endfunction

  // Drive one cycle of inputs from a negedge and return on the next negedge.
  task automatic applyStimulus(input logic [4:0] b, input logic fs, input logic r);
    {btn_center, btn_up, btn_down, btn_left, btn_right} = b;
    frame_start = fs;
    rst = r;
    @(negedge pclk);
    {btn_center, btn_up, btn_down, btn_left, btn_right} = 5'b0;
    frame_start = 1'b0;
    rst = 1'b0;
  endtask

  task automatic pulses(input logic [4:0] b, input int n);
    repeat (n) applyStimulus(b, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string name, input logic [11:0] actual, input logic [11:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  initial begin
    logic [4:0] rb;
    @(negedge pclk);
    applyStimulus(BN, 1'b0, 1'b1);
    applyStimulus(BN, 1'b0, 1'b1);
    pulses(BN, 10);
    checkOutput("reset_F60", getField(60), 12'h888);
    checkOutput("reset_F0", getField(0), 12'hB80);
    checkOutput("reset_F27", getField(27), 12'h000);
    checkOutput("reset_state", 12'(state), 12'h0);
    checkOutput("reset_turn", 12'(turn), 12'h0);
    checkOutput("reset_move_done", 12'(move_done), 12'h0);

    // Left edge clamp.
    pulses(BL, 4);
    checkOutput("left4_F56", getField(56), 12'hA88);
    pulses(BL, 1);
    checkOutput("left5_F56", getField(56), 12'hA88);
    checkOutput("left5_F60", getField(60), 12'h880);

    // White pawn 52 -> 36, held until frame_start.
    pulses(BR, 4);
    pulses(BU, 1);
    pulses(BC, 1);
    checkOutput("sel_state", 12'(state), 12'h1);
    checkOutput("sel_F52", getField(52), 12'h68C);
    pulses(BU, 2);
    pulses(BC, 1);
    checkOutput("drop_state", 12'(state), 12'h2);
    pulses(BN, 100);
    checkOutput("wait_state", 12'(state), 12'h2);
    checkOutput("wait_F36", getField(36), 12'h008);
    applyStimulus(BN, 1'b1, 1'b0);
    checkOutput("commit_F36", getField(36), 12'h688);
    checkOutput("commit_F52", getField(52), 12'h000);
    checkOutput("commit_turn", 12'(turn), 12'h1);
    checkOutput("commit_move_done", 12'(move_done), 12'h1);
    pulses(BN, 1);
    checkOutput("commit_move_done_drop", 12'(move_done), 12'h0);

    // Black to move: a white piece cannot be selected.
    pulses(BC, 1);
    checkOutput("wrongcamp_state", 12'(state), 12'h0);

    // Black knight selected, own-camp drop rejected, then capture on 36.
    pulses(BU, 4);
    pulses(BL, 3);
    pulses(BC, 1);
    checkOutput("knight_sel_F1", getField(1), 12'h38C);
    pulses(BD, 1);
    pulses(BC, 1);
    checkOutput("reject_state", 12'(state), 12'h1);
    checkOutput("reject_F9", getField(9), 12'h788);
    checkOutput("reject_F1", getField(1), 12'h384);
    pulses(BD, 3);
    pulses(BR, 3);
    pulses(BC, 1);
    checkOutput("capture_wait_state", 12'(state), 12'h2);
    applyStimulus(BN, 1'b1, 1'b0);
    checkOutput("capture_F36", getField(36), 12'h388);
    checkOutput("capture_F1", getField(1), 12'h000);
    checkOutput("capture_turn", 12'(turn), 12'h0);

    // Center beats up in the same cycle.
    pulses(BD, 2);
    pulses(BL, 1);
    applyStimulus(BC | BU, 1'b0, 1'b0);
    checkOutput("prio_state", 12'(state), 12'h1);
    checkOutput("prio_F51", getField(51), 12'h68C);
    checkOutput("prio_F43", getField(43), 12'h000);
    pulses(BC, 1);
    checkOutput("deselect_state", 12'(state), 12'h0);
    checkOutput("deselect_F51", getField(51), 12'h688);

    // Reset wins over a coincident commit.
    pulses(BC, 1);
    pulses(BU, 1);
    pulses(BC, 1);
    applyStimulus(BN, 1'b1, 1'b1);
    checkOutput("rstcommit_move_done", 12'(move_done), 12'h0);
    checkOutput("rstcommit_F60", getField(60), 12'h888);
    checkOutput("rstcommit_F51", getField(51), 12'h680);
    checkOutput("rstcommit_F52", getField(52), 12'h680);
    checkOutput("rstcommit_F43", getField(43), 12'h000);
    checkOutput("rstcommit_state", 12'(state), 12'h0);

    // Random traffic, checked every cycle by the model.
    repeat (4000) begin
      rb[4] = ($urandom_range(0, 3) == 0);
      rb[3] = ($urandom_range(0, 3) == 0);
      rb[2] = ($urandom_range(0, 3) == 0);
      rb[1] = ($urandom_range(0, 3) == 0);
      rb[0] = ($urandom_range(0, 3) == 0);
      applyStimulus(rb, $urandom_range(0, 7) == 0, $urandom_range(0, 599) == 0);
    end

    pulses(BN, 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
